// File: rtl/peripheral_mpram_axi4_dualport.sv
// AXI4 slave front-end for an external RAM with one write port and one read port.
// The read and write engines run independently, with one memory access per beat.
module peripheral_mpram_axi4_dualport #(
  parameter int  AXI_ID_WIDTH   = 10,
  parameter int  AXI_ADDR_WIDTH = 64,
  parameter int  AXI_DATA_WIDTH = 64,
  parameter int  MEM_WORDS      = 1024,
  localparam int B              = AXI_DATA_WIDTH / 8,
  localparam int LB             = $clog2(B),
  localparam int MW             = $clog2(MEM_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  // write address
  input  logic [AXI_ID_WIDTH-1:0]   axi_aw_id,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr,
  input  logic [7:0]                axi_aw_len,
  input  logic [2:0]                axi_aw_size,
  input  logic [1:0]                axi_aw_burst,
  input  logic                      axi_aw_valid,
  output logic                      axi_aw_ready,
  // write data
  input  logic [AXI_DATA_WIDTH-1:0] axi_w_data,
  input  logic [B-1:0]              axi_w_strb,
  input  logic                      axi_w_last,
  input  logic                      axi_w_valid,
  output logic                      axi_w_ready,
  // write response
  output logic [AXI_ID_WIDTH-1:0]   axi_b_id,
  output logic [1:0]                axi_b_resp,
  output logic                      axi_b_valid,
  input  logic                      axi_b_ready,
  // read address
  input  logic [AXI_ID_WIDTH-1:0]   axi_ar_id,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr,
  input  logic [7:0]                axi_ar_len,
  input  logic [2:0]                axi_ar_size,
  input  logic [1:0]                axi_ar_burst,
  input  logic                      axi_ar_valid,
  output logic                      axi_ar_ready,
  // read data
  output logic [AXI_ID_WIDTH-1:0]   axi_r_id,
  output logic [AXI_DATA_WIDTH-1:0] axi_r_data,
  output logic [1:0]                axi_r_resp,
  output logic                      axi_r_last,
  output logic                      axi_r_valid,
  input  logic                      axi_r_ready,
  // memory ports
  output logic                      mem_we_o,
  output logic [MW-1:0]             mem_waddr_o,
  output logic [B-1:0]              mem_wbe_o,
  output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
  output logic                      mem_re_o,
  output logic [MW-1:0]             mem_raddr_o,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);

  typedef logic [AXI_ADDR_WIDTH-1:0] addr_t;
  typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (int'(size) > LB) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  function automatic logic beat_oor(input addr_t a);
    return (a >> LB) >= addr_t'(MEM_WORDS);
  endfunction

  // WRAP keeps the upper address bits and lets only the low bits inside the window roll over.
  function automatic addr_t next_addr(input addr_t a, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    addr_t step, mask, inc;
    step = addr_t'(1) << size;
    mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    inc  = a + step;
    case (burst)
      2'b00:   return a;
      2'b10:   return (a & ~mask) | (inc & mask);
      default: return inc;
    endcase
  endfunction

  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic     ready_en_q;

  logic [AXI_ID_WIDTH-1:0]   ar_id_q, aw_id_q;
  addr_t                     ar_addr_q, aw_addr_q;
  logic [7:0]                ar_len_q, aw_len_q, r_cnt_q, w_cnt_q;
  logic [2:0]                ar_size_q, aw_size_q;
  logic [1:0]                ar_burst_q, aw_burst_q;
  logic                      ar_bad_q, aw_bad_q;
  logic                      r_err_q, r_valid_q, r_last_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [1:0]                r_resp_q, b_resp_q;
  logic                      w_over_q, w_err_q;
  logic                      r_beat_err, w_beat_err, w_fire, w_err_d;

  assign r_beat_err = ar_bad_q | beat_oor(ar_addr_q);
  assign w_beat_err = aw_bad_q | w_over_q | beat_oor(aw_addr_q);
  assign w_fire     = (w_state_q == W_DATA) && axi_w_valid;
  assign w_err_d    = w_err_q | w_beat_err | (axi_w_last & (w_over_q | (w_cnt_q != aw_len_q)));

  // Ready is held off until the first clock edge after reset is released.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state is updated only with non-blocking assignments.
    if (rst_i) begin
      r_state_q  <= R_IDLE;
      w_state_q  <= W_IDLE;
      ready_en_q <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      w_state_q  <= w_state_d;
      ready_en_q <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    r_state_d    = r_state_q;
    axi_ar_ready = 1'b0;
    mem_re_o     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        axi_ar_ready = ready_en_q;
        if (axi_ar_valid && ready_en_q) r_state_d = R_MEM;
      end
      R_MEM: begin
        mem_re_o  = !r_beat_err;
        r_state_d = R_RESP;
      end
      R_RESP: if (r_valid_q && axi_r_ready) r_state_d = r_last_q ? R_IDLE : R_MEM;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      ar_bad_q   <= 1'b0;
      r_cnt_q    <= '0;
      r_err_q    <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= '0;
      r_last_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (axi_ar_valid && axi_ar_ready) begin
          ar_id_q    <= axi_ar_id;
          ar_addr_q  <= axi_ar_addr;
          ar_len_q   <= axi_ar_len;
          ar_size_q  <= axi_ar_size;
          ar_burst_q <= axi_ar_burst;
          ar_bad_q   <= burst_bad(axi_ar_len, axi_ar_size, axi_ar_burst);
          r_cnt_q    <= '0;
        end
        R_MEM: r_err_q <= r_beat_err;
        R_RESP: begin
          // The first R_RESP cycle is the one in which the RAM presents its data.
          if (!r_valid_q) begin
            r_valid_q <= 1'b1;
            r_data_q  <= r_err_q ? '0 : mem_rdata_i;
            r_resp_q  <= r_err_q ? RESP_SLVERR : RESP_OKAY;
            r_last_q  <= (r_cnt_q == ar_len_q);
          end else if (axi_r_ready) begin
            r_valid_q <= 1'b0;
            r_cnt_q   <= r_cnt_q + 8'd1;
            ar_addr_q <= next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_d    = w_state_q;
    axi_aw_ready = 1'b0;
    axi_w_ready  = 1'b0;
    axi_b_valid  = 1'b0;
    mem_we_o     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        axi_aw_ready = ready_en_q;
        if (axi_aw_valid && ready_en_q) w_state_d = W_DATA;
      end
      W_DATA: begin
        axi_w_ready = 1'b1;
        mem_we_o    = axi_w_valid && !w_beat_err;
        if (axi_w_valid && axi_w_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        axi_b_valid = 1'b1;
        if (axi_b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      aw_bad_q   <= 1'b0;
      w_cnt_q    <= '0;
      w_over_q   <= 1'b0;
      w_err_q    <= 1'b0;
      b_resp_q   <= '0;
    end else if (w_state_q == W_IDLE) begin
      if (axi_aw_valid && axi_aw_ready) begin
        aw_id_q    <= axi_aw_id;
        aw_addr_q  <= axi_aw_addr;
        aw_len_q   <= axi_aw_len;
        aw_size_q  <= axi_aw_size;
        aw_burst_q <= axi_aw_burst;
        aw_bad_q   <= burst_bad(axi_aw_len, axi_aw_size, axi_aw_burst);
        w_cnt_q    <= '0;
        w_over_q   <= 1'b0;
        w_err_q    <= 1'b0;
      end
    end else if (w_fire) begin
      // Once beat len has been accepted, any further beats are dropped and flagged.
      w_cnt_q   <= w_cnt_q + 8'd1;
      aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
      w_err_q   <= w_err_d;
      if (w_cnt_q == aw_len_q) w_over_q <= 1'b1;
      if (axi_w_last) b_resp_q <= w_err_d ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign axi_r_id    = ar_id_q;
  assign axi_r_data  = r_data_q;
  assign axi_r_resp  = r_resp_q;
  assign axi_r_last  = r_last_q;
  assign axi_r_valid = r_valid_q;
  assign axi_b_id    = aw_id_q;
  assign axi_b_resp  = b_resp_q;
  assign mem_raddr_o = ar_addr_q[LB+MW-1:LB];
  assign mem_waddr_o = aw_addr_q[LB+MW-1:LB];
  assign mem_wbe_o   = mem_we_o ? axi_w_strb : '0;
  assign mem_wdata_o = mem_we_o ? axi_w_data : '0;

endmodule

// File: tb/tb_peripheral_mpram_axi4_dualport.sv
// Directed bench for peripheral_mpram_axi4_dualport with a registered-read RAM model.
module tb_peripheral_mpram_axi4_dualport;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  axi_aw_id, axi_ar_id, axi_b_id, axi_r_id;
  logic [63:0] axi_aw_addr, axi_ar_addr;
  logic [7:0]  axi_aw_len, axi_ar_len;
  logic [2:0]  axi_aw_size, axi_ar_size;
  logic [1:0]  axi_aw_burst, axi_ar_burst;
  logic        axi_aw_valid, axi_aw_ready, axi_ar_valid, axi_ar_ready;
  logic [63:0] axi_w_data, axi_r_data;
  logic [7:0]  axi_w_strb;
  logic        axi_w_last, axi_w_valid, axi_w_ready;
  logic [1:0]  axi_b_resp, axi_r_resp;
  logic        axi_b_valid, axi_b_ready, axi_r_last, axi_r_valid, axi_r_ready;
  logic        mem_we_o, mem_re_o;
  logic [9:0]  mem_waddr_o, mem_raddr_o;
  logic [7:0]  mem_wbe_o;
  logic [63:0] mem_wdata_o, mem_rdata_i;

  int checks = 0;
  int errors = 0;

  peripheral_mpram_axi4_dualport dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len),
    .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid),
    .axi_b_ready(axi_b_ready),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
    .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp),
    .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wbe_o(mem_wbe_o),
    .mem_wdata_o(mem_wdata_o), .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [63:0] old_word(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  // RAM model: read returns the contents before a same-edge write.
  logic [63:0] mem [0:1023];
  logic        mem_init;
  always @(posedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= old_word(i);
      mem_rdata_i <= '0;
    end else begin
      if (mem_re_o) mem_rdata_i <= mem[mem_raddr_o];
      if (mem_we_o)
        for (int b = 0; b < 8; b++)
          if (mem_wbe_o[b]) mem[mem_waddr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
    end
  end

  logic [9:0] re_q[$];
  logic [9:0] we_q[$];
  int         same_hits;
  always @(negedge clk_i) begin
    if (mem_re_o) re_q.push_back(mem_raddr_o);
    if (mem_we_o) we_q.push_back(mem_waddr_o);
    if (mem_re_o && mem_we_o && (mem_raddr_o == mem_waddr_o)) same_hits++;
  end

  logic [63:0] rd_data[$];
  logic [1:0]  rd_resp[$];
  logic        rd_last[$];
  logic [9:0]  rd_id[$];
  logic [1:0]  b_resp_got;
  logic [9:0]  b_id_got;

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_read(input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int stall_beat);
    int g, beats, nre;
    logic stalled, stable, sl;
    logic [63:0] sd;
    logic [1:0]  sr;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_id.delete(); re_q.delete();
    @(negedge clk_i);
    axi_ar_id = id; axi_ar_addr = addr; axi_ar_len = len;
    axi_ar_size = size; axi_ar_burst = burst; axi_ar_valid = 1'b1; axi_r_ready = 1'b1;
    g = 0;
    while (!axi_ar_ready && g < 100) begin @(negedge clk_i); g++; end
    @(negedge clk_i);
    axi_ar_valid = 1'b0;
    beats = 0; g = 0; stalled = 1'b0;
    while (beats <= int'(len) && g < 3000) begin
      if (axi_r_valid) begin
        if (beats == stall_beat && !stalled) begin
          stalled = 1'b1; axi_r_ready = 1'b0;
          sd = axi_r_data; sr = axi_r_resp; sl = axi_r_last; nre = re_q.size(); stable = 1'b1;
          repeat (5) begin
            @(negedge clk_i);
            if (!axi_r_valid || axi_r_data !== sd || axi_r_resp !== sr || axi_r_last !== sl)
              stable = 1'b0;
          end
          checks++;
          if (!stable) begin
            errors++; $display("FAIL stall_payload_stable got 0 exp 1");
          end
          checks++;
          if (re_q.size() != nre) begin
            errors++; $display("FAIL stall_no_mem_re got %0d exp %0d", re_q.size(), nre);
          end
          axi_r_ready = 1'b1;
        end
        rd_data.push_back(axi_r_data); rd_resp.push_back(axi_r_resp);
        rd_last.push_back(axi_r_last); rd_id.push_back(axi_r_id);
        beats++;
      end
      @(negedge clk_i); g++;
    end
    axi_r_ready = 1'b0;
    checks++;
    if (beats <= int'(len)) begin
      errors++; $display("FAIL read_timeout got %0d beats exp %0d", beats, int'(len) + 1);
    end
  endtask

  task automatic run_write(input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                           input logic [63:0] base);
    int g;
    we_q.delete(); b_resp_got = 2'b11; b_id_got = '1;
    @(negedge clk_i);
    fork
      begin
        int ga;
        axi_aw_id = id; axi_aw_addr = addr; axi_aw_len = len;
        axi_aw_size = size; axi_aw_burst = burst; axi_aw_valid = 1'b1;
        ga = 0;
        while (!axi_aw_ready && ga < 100) begin @(negedge clk_i); ga++; end
        @(negedge clk_i);
        axi_aw_valid = 1'b0;
      end
      begin
        int gw;
        for (int k = 0; k < nbeats; k++) begin
          axi_w_data = base + 64'(k); axi_w_strb = 8'hFF;
          axi_w_last = (k == nbeats - 1); axi_w_valid = 1'b1;
          gw = 0;
          while (!axi_w_ready && gw < 100) begin @(negedge clk_i); gw++; end
          @(negedge clk_i);
        end
        axi_w_valid = 1'b0; axi_w_last = 1'b0;
      end
    join
    axi_b_ready = 1'b1; g = 0;
    while (!axi_b_valid && g < 200) begin @(negedge clk_i); g++; end
    checks++;
    if (!axi_b_valid) begin
      errors++; $display("FAIL b_timeout got 0 exp 1");
    end else begin
      b_resp_got = axi_b_resp; b_id_got = axi_b_id;
    end
    @(negedge clk_i);
    axi_b_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_init = 1'b1;
    axi_aw_valid = 0; axi_ar_valid = 0; axi_w_valid = 0; axi_b_ready = 0; axi_r_ready = 0;
    axi_aw_id = '0; axi_aw_addr = '0; axi_aw_len = '0; axi_aw_size = '0; axi_aw_burst = '0;
    axi_ar_id = '0; axi_ar_addr = '0; axi_ar_len = '0; axi_ar_size = '0; axi_ar_burst = '0;
    axi_w_data = '0; axi_w_strb = '0; axi_w_last = 0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({axi_aw_ready, axi_ar_ready, axi_w_ready, axi_b_valid, axi_r_valid, mem_we_o, mem_re_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {axi_aw_ready, axi_ar_ready, axi_w_ready, axi_b_valid, axi_r_valid, mem_we_o, mem_re_o});
    end
    mem_init = 1'b0; rst_i = 1'b0;
    #1;
    checks++;
    if ({axi_aw_ready, axi_ar_ready} !== 2'b00) begin
      errors++; $display("FAIL ready_at_release got %b exp 00", {axi_aw_ready, axi_ar_ready});
    end
    @(negedge clk_i);
    checks++;
    if ({axi_aw_ready, axi_ar_ready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_release got %b exp 11", {axi_aw_ready, axi_ar_ready});
    end
  endtask

  task automatic test_incr_read();
    run_read(10'h155, 64'h40, 8'd3, 3'd3, 2'b01, -1);
    checks++;
    if (re_q.size() != 4) begin
      errors++; $display("FAIL incr_re_count got %0d exp 4", re_q.size());
    end
    for (int i = 0; i < re_q.size() && i < 4; i++) begin
      checks++;
      if (re_q[i] !== 10'(8 + i)) begin
        errors++; $display("FAIL incr_raddr%0d got %0h exp %0h", i, re_q[i], 8 + i);
      end
    end
    for (int i = 0; i < rd_data.size(); i++) begin
      checks++;
      if (rd_data[i] !== old_word(8 + i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)
          || rd_id[i] !== 10'h155) begin
        errors++;
        $display("FAIL incr_beat%0d got data %0h resp %0d last %0d id %0h exp %0h 0 %0d 155",
                 i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], old_word(8 + i), i == 3);
      end
    end
  endtask

  task automatic test_wrap_write();
    run_write(10'h2A3, 64'h18, 8'd3, 3'd3, 2'b10, 4, 64'h1111_2222_3333_0000);
    checks++;
    if (we_q.size() != 4 || we_q[0] !== 10'd3 || we_q[1] !== 10'd0 || we_q[2] !== 10'd1 || we_q[3] !== 10'd2) begin
      errors++; $display("FAIL wrap_waddr got %p exp 3 0 1 2", we_q);
    end
    checks++;
    if (b_resp_got !== 2'b00 || b_id_got !== 10'h2A3) begin
      errors++; $display("FAIL wrap_b got resp %0d id %0h exp 0 2a3", b_resp_got, b_id_got);
    end
    checks++;
    if (mem[3] !== 64'h1111_2222_3333_0000 || mem[0] !== 64'h1111_2222_3333_0001
        || mem[2] !== 64'h1111_2222_3333_0003) begin
      errors++; $display("FAIL wrap_mem got %0h %0h %0h", mem[3], mem[0], mem[2]);
    end
  endtask

  task automatic test_error_reads();
    run_read(10'h007, 64'h2000, 8'd0, 3'd3, 2'b01, -1);
    checks++;
    if (re_q.size() != 0) begin
      errors++; $display("FAIL oor_no_mem_re got %0d exp 0", re_q.size());
    end
    checks++;
    if (rd_data.size() != 1 || rd_resp[0] !== 2'b10 || rd_data[0] !== 64'h0 || rd_last[0] !== 1'b1) begin
      errors++; $display("FAIL oor_beat got resp %p data %p exp 2 0", rd_resp, rd_data);
    end
    run_read(10'h008, 64'h100, 8'd1, 3'd4, 2'b01, -1);
    checks++;
    if (re_q.size() != 0 || rd_resp.size() != 2 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10
        || rd_last[1] !== 1'b1) begin
      errors++; $display("FAIL bad_size_read got re %0d resp %p exp 0 2 2", re_q.size(), rd_resp);
    end
  endtask

  task automatic test_backpressure();
    run_read(10'h033, 64'h80, 8'd3, 3'd3, 2'b01, 1);
    checks++;
    if (re_q.size() != 4 || rd_data.size() != 4 || rd_data[1] !== old_word(17) || rd_data[3] !== old_word(19)) begin
      errors++; $display("FAIL stall_burst got re %0d data %p", re_q.size(), rd_data);
    end
  endtask

  task automatic test_concurrent();
    same_hits = 0;
    fork
      run_read(10'h011, 64'h800, 8'd15, 3'd3, 2'b01, -1);
      run_write(10'h022, 64'h800, 8'd15, 3'd3, 2'b01, 16, 64'h7700_0000_0000_0000);
    join
    checks++;
    if (same_hits < 1) begin
      errors++; $display("FAIL conc_same_cycle got %0d exp >=1", same_hits);
    end
    checks++;
    if (rd_data.size() != 16 || rd_data[0] !== old_word(12'h100)) begin
      errors++; $display("FAIL conc_old_data got %0h exp %0h", rd_data[0], old_word(12'h100));
    end
    for (int k = 1; k < rd_data.size(); k++) begin
      checks++;
      if (rd_data[k] !== 64'h7700_0000_0000_0000 + 64'(k) || rd_last[k] !== (k == 15)) begin
        errors++; $display("FAIL conc_beat%0d got %0h exp %0h", k, rd_data[k], 64'h7700_0000_0000_0000 + 64'(k));
      end
    end
    checks++;
    if (we_q.size() != 16 || b_resp_got !== 2'b00 || b_id_got !== 10'h022) begin
      errors++; $display("FAIL conc_write got we %0d resp %0d id %0h exp 16 0 22", we_q.size(), b_resp_got, b_id_got);
    end
  endtask

  task automatic test_write_errors();
    run_write(10'h0F0, 64'h200, 8'd3, 3'd3, 2'b01, 2, 64'hAAAA_0000_0000_0000);
    checks++;
    if (b_resp_got !== 2'b10 || b_id_got !== 10'h0F0) begin
      errors++; $display("FAIL early_last got resp %0d id %0h exp 2 f0", b_resp_got, b_id_got);
    end
    run_write(10'h0F1, 64'h300, 8'd2, 3'd3, 2'b10, 3, 64'hBBBB_0000_0000_0000);
    checks++;
    if (b_resp_got !== 2'b10 || we_q.size() != 0) begin
      errors++; $display("FAIL bad_wrap_len got resp %0d we %0d exp 2 0", b_resp_got, we_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    logic seen;
    @(negedge clk_i);
    axi_aw_id = 10'h3C3; axi_aw_addr = 64'h1800; axi_aw_len = 8'd3; axi_aw_size = 3'd3;
    axi_aw_burst = 2'b01; axi_aw_valid = 1'b1;
    axi_ar_id = 10'h3C4; axi_ar_addr = 64'h1800; axi_ar_len = 8'd3; axi_ar_size = 3'd3;
    axi_ar_burst = 2'b01; axi_ar_valid = 1'b1;
    @(negedge clk_i);
    axi_aw_valid = 1'b0; axi_ar_valid = 1'b0;
    axi_w_data = 64'h1234; axi_w_strb = 8'hFF; axi_w_last = 1'b0; axi_w_valid = 1'b1;
    @(negedge clk_i);
    axi_w_valid = 1'b0;
    rst_i = 1'b1;
    #1;
    checks++;
    if ({axi_aw_ready, axi_ar_ready, axi_w_ready, axi_b_valid, axi_r_valid, mem_we_o, mem_re_o} !== 7'b0) begin
      errors++;
      $display("FAIL midreset_ctrl got %b exp 0",
               {axi_aw_ready, axi_ar_ready, axi_w_ready, axi_b_valid, axi_r_valid, mem_we_o, mem_re_o});
    end
    checks++;
    if ({axi_r_data, axi_r_resp, axi_r_last, axi_r_id, axi_b_id, axi_b_resp, mem_wdata_o, mem_wbe_o,
         mem_raddr_o, mem_waddr_o} !== '0) begin
      errors++; $display("FAIL midreset_payload got nonzero exp 0");
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0; axi_b_ready = 1'b1; axi_r_ready = 1'b1; seen = 1'b0;
    repeat (10) begin
      @(negedge clk_i);
      if (axi_b_valid || axi_r_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL midreset_no_response got 1 exp 0");
    end
    checks++;
    if ({axi_aw_ready, axi_ar_ready} !== 2'b11) begin
      errors++; $display("FAIL midreset_idle got %b exp 11", {axi_aw_ready, axi_ar_ready});
    end
    axi_b_ready = 1'b0; axi_r_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_incr_read();
    test_wrap_write();
    test_error_reads();
    test_backpressure();
    test_concurrent();
    test_write_errors();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/peripheral_mpram_axi4_dualport.md
PERIPHERAL_MPRAM_AXI4_DUALPORT -- requirements
Module: peripheral_mpram_axi4_dualport

Interface
REQ-001 SHALL have parameter AXI_ID_WIDTH, default 10, AXI ID width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 64, byte address width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 64, data width (power of two, >=32); B=AXI_DATA_WIDTH/8, LB=log2(B).
REQ-004 SHALL have parameter MEM_WORDS, default 1024, memory depth in words; MW=log2(MEM_WORDS).
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i, rst_i.
REQ-006 Ports (name  direction  width  meaning):
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active high
- axi_aw_id/addr/len/size/burst  in  ID/ADDR/8/3/2  write address payload
- axi_aw_valid, axi_aw_ready  in, out  1, 1  AW handshake
- axi_w_data/strb/last  in  DATA/B/1  write data payload
- axi_w_valid, axi_w_ready  in, out  1, 1  W handshake
- axi_b_id/resp  out  ID/2  write response
- axi_b_valid, axi_b_ready  out, in  1, 1  B handshake
- axi_ar_id/addr/len/size/burst  in  ID/ADDR/8/3/2  read address payload
- axi_ar_valid, axi_ar_ready  in, out  1, 1  AR handshake
- axi_r_id/data/resp/last  out  ID/DATA/2/1  read data payload
- axi_r_valid, axi_r_ready  out, in  1, 1  R handshake
- mem_we_o/waddr_o/wbe_o/wdata_o  out  1/MW/B/DATA  memory write port
- mem_re_o/raddr_o  out  1/MW  memory read port
- mem_rdata_i  in  DATA  read data, valid exactly 1 cycle after mem_re_o

Function
REQ-007 Read and write engines SHALL run concurrently and independently; neither stalls the other.
REQ-008 Beat address: FIXED = start addr every beat; INCR = +2^size per beat; WRAP = +2^size, wrapping within the (len+1)*2^size-aligned window containing start addr.
REQ-009 Memory word index SHALL be beat_addr[LB+MW-1:LB]; beat is out-of-range if beat_addr >> LB >= MEM_WORDS.
REQ-010 Burst-level error: size > LB, or WRAP with len not in {1,3,7,15}, or burst=2'b11; every beat of such a burst SHALL be SLVERR (2'b10) with no memory access.
REQ-011 Out-of-range beat SHALL return SLVERR with no memory access; in-range beat OKAY (2'b00).
REQ-012 Read FSM R_IDLE/R_MEM/R_RESP: R_IDLE asserts axi_ar_ready=1, AR handshake captures payload -> R_MEM.
REQ-013 R_MEM: pulse mem_re_o for one cycle (suppressed on error beat) -> R_RESP; next cycle register mem_rdata_i (0 on error) and assert axi_r_valid.
REQ-014 R_RESP: hold r_valid, r_data, r_resp, r_id stable until r_ready; r_last=1 on beat len; on handshake -> R_MEM (next beat) or R_IDLE (last).
REQ-015 Write FSM W_IDLE/W_DATA/W_RESP: W_IDLE asserts axi_aw_ready=1; AW handshake -> W_DATA.
REQ-016 W_DATA: axi_w_ready=1; each W handshake drives mem_we_o=1 for that cycle with wbe_o=w_strb, wdata_o=w_data (suppressed on error beat); w_last -> W_RESP.
REQ-017 Write response SLVERR if any beat errored or w_last arrives on a beat other than beat len (early: terminate; late: beats past len discarded, no write); else OKAY.
REQ-018 W_RESP: axi_b_valid=1, b_id=captured aw_id, held until b_ready -> W_IDLE.
REQ-019 Same-cycle read and write to same word: read SHALL return pre-write data; no forwarding.
REQ-020 Beat counters SHALL be 8 bit; address arithmetic at AXI_ADDR_WIDTH, wrapping modulo 2^AXI_ADDR_WIDTH.

Reset
REQ-021 rst_i high SHALL immediately force R_IDLE, W_IDLE and all outputs 0 (aw/ar_ready rise the first cycle after release); in-flight bursts are discarded without response.

Verification
REQ-022 INCR read addr 0x40, len 3, size 3 -> raddr 8,9,10,11; 4 beats OKAY, r_last on 4th only.
REQ-023 WRAP write addr 0x18, len 3, size 3 -> waddr 3,0,1,2; B OKAY with aw_id.
REQ-024 Read addr 0x2000 (MEM_WORDS 1024) -> no mem_re_o, r_resp 2'b10, r_data 0.
REQ-025 r_ready low 5 cycles mid-burst -> R payload stable, no further mem_re_o.
REQ-026 Concurrent 16-beat read and write, same cycle -> both complete, no stall; same-word read returns old data.
REQ-027 w_last on beat 1 of len 3 burst -> b_resp 2'b10; rst_i mid-burst -> all outputs 0, no B.
